// File: rtl/uart_rx_vote_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_vote_sampler
//
// Oversampling data sampler for the UART receiver. A local edge counter is
// realigned by bit_start and otherwise wraps every Prescale clocks. Around
// the bit midpoint NUM_SAMPLES consecutive oversamples of RX_IN are
// collected. One clock after the last sample the collected ones are
// majority-voted into sampled_bit. noise_flag reports whether the samples
// disagreed.
//
// Parameters
//   PRESCALE_W   width of Prescale and of the edge counter
//   NUM_SAMPLES  samples per bit, odd, 1..7
//
// Ports
//   clk           system clock (RX domain)
//   reset         asynchronous active-low reset
//   samp_en       sampler enable; low flushes the counter and accumulator
//   bit_start     1-cycle strobe, edge counter restarts at 0 next cycle
//   Prescale      clocks per bit (even)
//   RX_IN         synchronised serial input
//   edge_cnt      current edge count within the bit
//   bit_done      1-cycle pulse the cycle after the last edge of a bit
//   sampled_bit   registered majority vote of the last completed bit
//   samp_valid    1-cycle pulse when sampled_bit/noise_flag were updated
//   noise_flag    samples of the last voted bit were not unanimous
//   prescale_err  Prescale cannot hold the sample window for NUM_SAMPLES
// ---------------------------------------------------------------------------
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  samp_en,
    input  logic                  bit_start,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  RX_IN,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  bit_done,
    output logic                  sampled_bit,
    output logic                  samp_valid,
    output logic                  noise_flag,
    output logic                  prescale_err
);

    localparam int HALF = (NUM_SAMPLES - 1) / 2;
    // One extra bit keeps midpoint/window arithmetic free of wrap-around.
    localparam int XW = PRESCALE_W + 1;
    localparam logic [XW-1:0] HALF_X = XW'(HALF);
    localparam logic [2:0]    HALF_3 = 3'(HALF);
    localparam logic [2:0]    NUM_3  = 3'(NUM_SAMPLES);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [2:0]            ones_q;
    logic [2:0]            taken_q;

    logic [XW-1:0] presc_x;
    logic [XW-1:0] cnt_x;
    logic [XW-1:0] mid_edge;
    logic [XW-1:0] last_samp_edge;
    logic [XW-1:0] vote_edge;
    logic [XW-1:0] last_edge;

    logic sample_edge;
    logic at_vote_edge;
    logic at_last_edge;
    logic counter_wrap;
    logic run;
    logic do_sample;
    logic do_vote;
    logic vote_ok;

    assign edge_cnt = cnt_q;

    // Window geometry derived from the live Prescale value, so a change
    // takes effect on the very next compare. When Prescale is too small
    // the midpoint may underflow, but prescale_err is then already set
    // and gates all sampling and voting.
    always_comb begin
        presc_x        = {1'b0, Prescale};
        cnt_x          = {1'b0, cnt_q};
        mid_edge       = (presc_x >> 1) - XW'(1);
        last_samp_edge = mid_edge + HALF_X;
        vote_edge      = last_samp_edge + XW'(1);
        last_edge      = presc_x - XW'(1);

        prescale_err   = (presc_x < XW'(4)) || Prescale[0] ||
                         (mid_edge < HALF_X) || (vote_edge > last_edge);

        // cnt >= mid-HALF is written as cnt+HALF >= mid to avoid underflow.
        sample_edge    = ((cnt_x + HALF_X) >= mid_edge) &&
                         (cnt_x <= last_samp_edge);
        at_vote_edge   = (cnt_x == vote_edge);
        at_last_edge   = (cnt_x == last_edge);
        // >= rather than == so that a Prescale drop mid-bit still wraps.
        counter_wrap   = (cnt_x >= last_edge);
    end

    // bit_start outranks every counter and accumulator action.
    assign run       = samp_en && !bit_start;
    assign do_sample = run && !prescale_err && sample_edge;
    assign do_vote   = run && !prescale_err && at_vote_edge;
    // A vote is only published if the whole window was seen for this bit.
    // A window cut short by a Prescale change is therefore dropped.
    assign vote_ok   = do_vote && (taken_q == NUM_3);

    // Edge counter: cleared when idle or realigned, else wraps per bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (counter_wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

    // Accumulator: ones seen and samples taken in the current window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_q  <= '0;
            taken_q <= '0;
        end else if (!run || do_vote) begin
            ones_q  <= '0;
            taken_q <= '0;
        end else if (do_sample) begin
            ones_q  <= ones_q + {2'b00, RX_IN};
            taken_q <= taken_q + 3'd1;
        end
    end

    // Vote result. sampled_bit and noise_flag hold between votes and
    // across samp_en=0, only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sampled_bit <= 1'b0;
            noise_flag  <= 1'b0;
            samp_valid  <= 1'b0;
        end else begin
            samp_valid <= vote_ok;
            if (vote_ok) begin
                sampled_bit <= (ones_q > HALF_3);
                noise_flag  <= (ones_q != 3'd0) && (ones_q != NUM_3);
            end
        end
    end

    // End-of-bit pulse, suppressed by a same-cycle bit_start or samp_en=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_done <= 1'b0;
        end else begin
            bit_done <= run && at_last_edge;
        end
    end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_vote_sampler
//
// Two sampler instances: index 0 with NUM_SAMPLES=3, index 1 with
// NUM_SAMPLES=5. Only one instance is driven at a time, the other idles
// with samp_en=0. Stimulus tasks describe whole bits (sample values inside
// the window, random values outside it). From the window position and vote
// arithmetic they schedule the per-cycle expected outputs into arrays
// indexed by clock number. One compare process checks both instances every
// cycle. Literal checks pin timing and counts at key points.
// ---------------------------------------------------------------------------
module tb_uart_rx_vote_sampler;

    localparam int NCYC = 4096;

    logic       clk;
    logic       reset;
    logic       samp_en   [2];
    logic       bit_start [2];
    logic [5:0] presc     [2];
    logic       rx_in     [2];
    logic [5:0] d_cnt     [2];
    logic       d_done    [2];
    logic       d_bit     [2];
    logic       d_valid   [2];
    logic       d_noise   [2];
    logic       d_err     [2];

    int vectors;
    int miscompares;
    int cyc;

    // Scheduled expectations, indexed [instance][clock number].
    bit e_chk   [2][NCYC];
    int e_cnt   [2][NCYC];
    bit e_valid [2][NCYC];
    bit e_done  [2][NCYC];
    bit e_bit   [2][NCYC];
    bit e_noise [2][NCYC];

    // Model of the held vote result per instance.
    bit m_bit   [2];
    bit m_noise [2];

    // Observed pulse bookkeeping for the literal checks.
    int valid_cnt      [2];
    int done_cnt       [2];
    int last_valid_cyc [2];
    int last_done_cyc  [2];
    int first_valid_cyc[2];

    uart_rx_vote_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(3)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .samp_en      (samp_en[0]),
        .bit_start    (bit_start[0]),
        .Prescale     (presc[0]),
        .RX_IN        (rx_in[0]),
        .edge_cnt     (d_cnt[0]),
        .bit_done     (d_done[0]),
        .sampled_bit  (d_bit[0]),
        .samp_valid   (d_valid[0]),
        .noise_flag   (d_noise[0]),
        .prescale_err (d_err[0])
    );

    uart_rx_vote_sampler #(.PRESCALE_W(6), .NUM_SAMPLES(5)) dut5 (
        .clk          (clk),
        .reset        (reset),
        .samp_en      (samp_en[1]),
        .bit_start    (bit_start[1]),
        .Prescale     (presc[1]),
        .RX_IN        (rx_in[1]),
        .edge_cnt     (d_cnt[1]),
        .bit_done     (d_done[1]),
        .sampled_bit  (d_bit[1]),
        .samp_valid   (d_valid[1]),
        .noise_flag   (d_noise[1]),
        .prescale_err (d_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nsamp_of(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    // Window legality: midpoint c=P/2-1, window c-HALF..c+HALF, vote at
    // c+HALF+1 which must still lie inside the bit.
    function automatic bit err_of(input int p, input int n);
        int half;
        int c;
        int v;
        half = (n - 1) / 2;
        c    = p / 2 - 1;
        v    = c + half + 1;
        return (p < 4) || (p % 2 != 0) || (c < half) || (v > p - 1);
    endfunction

    task automatic check_output(input string name, input int i,
                                input logic [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d cyc=%0d got=%0d want=%0d",
                     name, i, cyc, act, exp);
        end
    endtask

    // Drive instance i for one clock, idle the other, and record what both
    // must show after the coming clock edge.
    task automatic apply_stimulus(input int i, input bit en, input bit bs,
                                  input bit rx, input int ecnt,
                                  input bit evalid, input bit edone,
                                  input bit vbit, input bit vnoise);
        int k;
        int o;
        o = 1 - i;
        samp_en[i]   = en;
        bit_start[i] = bs;
        rx_in[i]     = rx;
        samp_en[o]   = 1'b0;
        bit_start[o] = 1'b0;
        k = cyc + 1;
        if (evalid) begin
            m_bit[i]   = vbit;
            m_noise[i] = vnoise;
        end
        if (k < NCYC) begin
            e_chk[i][k]   = 1'b1;
            e_cnt[i][k]   = ecnt;
            e_valid[i][k] = evalid;
            e_done[i][k]  = edone;
            e_bit[i][k]   = m_bit[i];
            e_noise[i][k] = m_noise[i];
            e_chk[o][k]   = 1'b1;
            e_cnt[o][k]   = 0;
            e_valid[o][k] = 1'b0;
            e_done[o][k]  = 1'b0;
            e_bit[o][k]   = m_bit[o];
            e_noise[o][k] = m_noise[o];
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply_stimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // bit_start, then up to 'limit' clocks of bits that follow each other
    // by counter wrap. pat holds NUM_SAMPLES window samples per bit,
    // bit b sample j at pat[b*n+j].
    task automatic run_bits(input int i, input int p, input int nbits,
                            input int limit, input logic [63:0] pat);
        int n;
        int half;
        int c;
        int lo;
        int v;
        int ones;
        int steps;
        bit err;
        bit rx;
        n    = nsamp_of(i);
        half = (n - 1) / 2;
        c    = p / 2 - 1;
        lo   = c - half;
        v    = c + half + 1;
        err  = err_of(p, n);
        presc[i] = 6'(p);
        apply_stimulus(i, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        ones  = 0;
        steps = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int e = 0; e < p; e++) begin
                if (steps < limit) begin
                    if (!err && e >= lo && e <= c + half) begin
                        rx   = pat[b * n + e - lo];
                        ones = ones + int'(rx);
                    end else begin
                        rx = 1'($urandom_range(0, 1));
                    end
                    apply_stimulus(i, 1'b1, 1'b0, rx,
                                   (e == p - 1) ? 0 : e + 1,
                                   !err && (e == v), (e == p - 1),
                                   ones > half, (ones != 0) && (ones != n));
                    if (e == v) ones = 0;
                    steps++;
                end
            end
        end
    endtask

    // Compare process: every clock, both instances against the schedule.
    always begin
        @(posedge clk);
        cyc++;
        #2;
        for (int i = 0; i < 2; i++) begin
            if (d_valid[i] === 1'b1) begin
                valid_cnt[i]++;
                last_valid_cyc[i] = cyc;
                if (first_valid_cyc[i] < 0) first_valid_cyc[i] = cyc;
            end
            if (d_done[i] === 1'b1) begin
                done_cnt[i]++;
                last_done_cyc[i] = cyc;
            end
            if (cyc < NCYC && e_chk[i][cyc]) begin
                check_output("edge_cnt",     i, 32'(d_cnt[i]),   e_cnt[i][cyc]);
                check_output("samp_valid",   i, 32'(d_valid[i]), int'(e_valid[i][cyc]));
                check_output("bit_done",     i, 32'(d_done[i]),  int'(e_done[i][cyc]));
                check_output("sampled_bit",  i, 32'(d_bit[i]),   int'(e_bit[i][cyc]));
                check_output("noise_flag",   i, 32'(d_noise[i]), int'(e_noise[i][cyc]));
                check_output("prescale_err", i, 32'(d_err[i]),
                             int'(err_of(int'(presc[i]), nsamp_of(i))));
            end
        end
    end

    initial begin
        int k0;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            samp_en[i]         = 1'b0;
            bit_start[i]       = 1'b0;
            rx_in[i]           = 1'b0;
            m_bit[i]           = 1'b0;
            m_noise[i]         = 1'b0;
            valid_cnt[i]       = 0;
            done_cnt[i]        = 0;
            last_valid_cyc[i]  = -1;
            last_done_cyc[i]   = -1;
            first_valid_cyc[i] = -1;
        end
        presc[0] = 6'd8;
        presc[1] = 6'd16;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_output("rst_edge_cnt",    i, 32'(d_cnt[i]),   0);
            check_output("rst_sampled_bit", i, 32'(d_bit[i]),   0);
            check_output("rst_samp_valid",  i, 32'(d_valid[i]), 0);
            check_output("rst_bit_done",    i, 32'(d_done[i]),  0);
            check_output("rst_noise_flag",  i, 32'(d_noise[i]), 0);
        end
        reset = 1'b1;
        idle_cycles(2);

        $display("[TB] N=3 P=8 samples 1,0,1");
        k0 = cyc;
        run_bits(0, 8, 1, 8, 64'b101);
        check_output("t1_valid_cycle", 0, 32'(last_valid_cyc[0] - k0), 7);
        check_output("t1_done_cycle",  0, 32'(last_done_cyc[0] - k0),  9);
        check_output("t1_sampled_bit", 0, 32'(d_bit[0]),   1);
        check_output("t1_noise_flag",  0, 32'(d_noise[0]), 1);

        $display("[TB] N=3 P=8 bit_start at sample edge 3");
        valid_cnt[0] = 0;
        run_bits(0, 8, 1, 3, 64'b111);
        run_bits(0, 8, 1, 8, 64'b000);
        check_output("abort_valid_count", 0, 32'(valid_cnt[0]), 1);
        check_output("abort_sampled_bit", 0, 32'(d_bit[0]),     0);
        check_output("abort_noise_flag",  0, 32'(d_noise[0]),   0);

        $display("[TB] samp_en drop at edge 4");
        run_bits(0, 8, 2, 12, 64'b000_111);
        idle_cycles(1);
        check_output("drop_edge_cnt",    0, 32'(d_cnt[0]),   0);
        check_output("drop_samp_valid",  0, 32'(d_valid[0]), 0);
        check_output("drop_sampled_bit", 0, 32'(d_bit[0]),   1);

        $display("[TB] asynchronous reset mid-bit");
        run_bits(0, 8, 1, 4, 64'b000);
        check_output("pre_rst_edge_cnt",    0, 32'(d_cnt[0]), 4);
        check_output("pre_rst_sampled_bit", 0, 32'(d_bit[0]), 1);
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("arst_edge_cnt",    i, 32'(d_cnt[i]),   0);
            check_output("arst_sampled_bit", i, 32'(d_bit[i]),   0);
            check_output("arst_samp_valid",  i, 32'(d_valid[i]), 0);
            check_output("arst_bit_done",    i, 32'(d_done[i]),  0);
            check_output("arst_noise_flag",  i, 32'(d_noise[i]), 0);
            m_bit[i]   = 1'b0;
            m_noise[i] = 1'b0;
        end
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle_cycles(2);

        $display("[TB] N=5 P=16 ten bits");
        valid_cnt[1]       = 0;
        done_cnt[1]        = 0;
        first_valid_cyc[1] = -1;
        k0 = cyc;
        run_bits(1, 16, 10, 160, 64'h0003_9AC5_6F1E_8B40);
        check_output("t2_valid_count",  1, 32'(valid_cnt[1]), 10);
        check_output("t2_done_count",   1, 32'(done_cnt[1]),  10);
        check_output("t2_first_valid",  1, 32'(first_valid_cyc[1] - k0), 12);

        $display("[TB] N=5 Prescale 8, 6, 4");
        presc[1] = 6'd8;
        #1;
        check_output("err_p8", 1, 32'(d_err[1]), 0);
        valid_cnt[1] = 0;
        run_bits(1, 8, 2, 16, 64'b01011_11000);
        check_output("p8_valid_count", 1, 32'(valid_cnt[1]), 2);
        presc[1] = 6'd6;
        #1;
        check_output("err_p6", 1, 32'(d_err[1]), 0);
        valid_cnt[1] = 0;
        run_bits(1, 6, 2, 12, 64'b11111_00100);
        check_output("p6_valid_count", 1, 32'(valid_cnt[1]), 2);
        presc[1] = 6'd4;
        #1;
        check_output("err_p4", 1, 32'(d_err[1]), 1);
        valid_cnt[1] = 0;
        done_cnt[1]  = 0;
        run_bits(1, 4, 3, 12, 64'b0);
        check_output("p4_valid_count", 1, 32'(valid_cnt[1]), 0);
        check_output("p4_done_count",  1, 32'(done_cnt[1]),  3);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
